// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor; two of these plus an OR form the per-bit full
// subtractor used by the serial datapath.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic borrow
);

  // Difference is the XOR, borrow occurs when subtracting 1 from 0.
  always_comb begin
    diff   = x ^ y;
    borrow = ~x & y;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor computing a-b modulo 2^WIDTH, LSB first,
// one bit per SHIFT cycle.
// Optional compare flags (a_lt_b, a_eq_b) are built only when the macro
// SERIAL_SUBTRACTOR_COMPARE_EN is defined; otherwise both ports read 0.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             d_bit,
  output logic             d_valid,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aReg_q, aReg_d;
  logic [WIDTH-1:0] bReg_q, bReg_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hs1Diff, hs1Borrow, hs2Diff, hs2Borrow;
  logic bitBorrow;
  logic lastBit;

  // First half subtractor handles a0 - b0.
  half_subtractor uHs1 (
    .x      (aReg_q[0]),
    .y      (bReg_q[0]),
    .diff   (hs1Diff),
    .borrow (hs1Borrow)
  );

  // Second half subtractor folds in the borrow carried from the previous bit.
  half_subtractor uHs2 (
    .x      (hs1Diff),
    .y      (borrow_q),
    .diff   (hs2Diff),
    .borrow (hs2Borrow)
  );

  assign bitBorrow = hs1Borrow | hs2Borrow;
  assign lastBit   = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (lastBit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy    = (state_q == SHIFT);
    done    = (state_q == DONE);
    d_valid = busy;
    d_bit   = busy ? hs2Diff : 1'b0;
  end

  // Datapath next values: load operands on start, shift one bit per SHIFT cycle.
  always_comb begin
    aReg_d   = aReg_q;
    bReg_d   = bReg_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          aReg_d   = a;
          bReg_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      SHIFT: begin
        aReg_d   = aReg_q >> 1;
        bReg_d   = bReg_q >> 1;
        diff_d   = {hs2Diff, diff_q[WIDTH-1:1]};
        borrow_d = bitBorrow;
        if (!lastBit) cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      aReg_q   <= '0;
      bReg_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      aReg_q   <= aReg_d;
      bReg_q   <= bReg_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;

`ifdef SERIAL_SUBTRACTOR_COMPARE_EN
  logic zero_q, zero_d;
  logic ltFlag_q, ltFlag_d;
  logic eqFlag_q, eqFlag_d;

  // Compare flags: sticky zero tracks whether every difference bit was 0;
  // both flags are committed on the final SHIFT bit so they appear in DONE.
  always_comb begin
    zero_d   = zero_q;
    ltFlag_d = ltFlag_q;
    eqFlag_d = eqFlag_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          zero_d   = 1'b1;
          ltFlag_d = 1'b0;
          eqFlag_d = 1'b0;
        end
      end
      SHIFT: begin
        zero_d = zero_q & ~hs2Diff;
        if (lastBit) begin
          ltFlag_d = bitBorrow;
          eqFlag_d = zero_q & ~hs2Diff;
        end
      end
      default: ;
    endcase
  end

  // Compare flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q   <= 1'b0;
      ltFlag_q <= 1'b0;
      eqFlag_q <= 1'b0;
    end else begin
      zero_q   <= zero_d;
      ltFlag_q <= ltFlag_d;
      eqFlag_q <= eqFlag_d;
    end
  end

  assign a_lt_b = ltFlag_q;
  assign a_eq_b = eqFlag_q;
`else
  assign a_lt_b = 1'b0;
  assign a_eq_b = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed operand vectors with
// hand-computed results pushed to a scoreboard, a monitor that checks the
// serial bit stream and the final result whenever the DUT presents them.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, borrowOut, dBit, dValid, aLtB, aEqB;
  logic [7:0] diff;

  logic       start2;
  logic [1:0] a2, b2;
  logic       busy2, done2, borrowOut2, dBit2, dValid2, aLtB2, aEqB2;
  logic [1:0] diff2;

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
    logic       lt;
    logic       eq;
  } result_t;

  result_t resultQ[$];
  logic    bitQ[$];

  int checks = 0;
  int errors = 0;
  int doneCount = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrowOut),
    .d_bit(dBit), .d_valid(dValid), .a_lt_b(aLtB), .a_eq_b(aEqB)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow_out(borrowOut2),
    .d_bit(dBit2), .d_valid(dValid2), .a_lt_b(aLtB2), .a_eq_b(aEqB2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected serial bits on d_valid and expected results on done.
  always @(negedge clk) begin
    if (!rst) begin
      if (dValid) begin
        if (bitQ.size() == 0) begin
          checkOutput("unexpected d_valid", 1, 0);
        end else begin
          checkOutput("d_bit", dBit, bitQ.pop_front());
        end
      end
      if (done) begin
        doneCount++;
        if (resultQ.size() == 0) begin
          checkOutput("unexpected done", 1, 0);
        end else begin
          result_t r;
          r = resultQ.pop_front();
          checkOutput("diff", diff, r.diff);
          checkOutput("borrow_out", borrowOut, r.borrow);
          checkOutput("a_lt_b", aLtB, r.lt);
          checkOutput("a_eq_b", aEqB, r.eq);
        end
      end
    end
  end

  task automatic pushExpected(input logic [7:0] expDiff, input logic expBorrow);
    result_t r;
    r.diff   = expDiff;
    r.borrow = expBorrow;
`ifdef SERIAL_SUBTRACTOR_COMPARE_EN
    r.lt = expBorrow;
    r.eq = (expDiff == 8'd0) && !expBorrow;
`else
    r.lt = 1'b0;
    r.eq = 1'b0;
`endif
    resultQ.push_back(r);
    for (int i = 0; i < 8; i++) bitQ.push_back(expDiff[i]);
  endtask

  // Drive one start pulse; returns just after the accepting edge.
  task automatic driveStart(input logic [7:0] aIn, input logic [7:0] bIn);
    @(posedge clk); #1;
    start = 1'b1; a = aIn; b = bIn;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Full operation with latency, busy-length and hold checks.
  task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn,
                               input logic [7:0] expDiff, input logic expBorrow);
    int lat;
    int busyN;
    pushExpected(expDiff, expBorrow);
    driveStart(aIn, bIn);
    lat = 0;
    busyN = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busyN++;
      if (done) break;
    end
    checkOutput("latency", lat, 9);
    checkOutput("busy cycles", busyN, 8);
    @(negedge clk);
    checkOutput("done one-cycle", done, 0);
    checkOutput("diff held", diff, expDiff);
    checkOutput("borrow held", borrowOut, expBorrow);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " d_valid"}, dValid, 0);
    checkOutput({tag, " d_bit"}, dBit, 0);
    checkOutput({tag, " diff"}, diff, 0);
    checkOutput({tag, " borrow_out"}, borrowOut, 0);
    checkOutput({tag, " a_lt_b"}, aLtB, 0);
    checkOutput({tag, " a_eq_b"}, aEqB, 0);
  endtask

  initial begin
    int doneBefore;
    int lat;
    int busyN;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    checkOutput("reset diff2", diff2, 0);
    checkOutput("reset busy2", busy2, 0);

    // Start asserted together with reset must be ignored.
    @(posedge clk); #1;
    start = 1'b1; a = 8'd1; b = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rst over start busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(8'd200, 8'd55, 8'd145, 1'b0);
    applyStimulus(8'd5, 8'd10, 8'd251, 1'b1);
    applyStimulus(8'hAA, 8'hAA, 8'd0, 1'b0);
    applyStimulus(8'd0, 8'd255, 8'd1, 1'b1);

    // start pulses during SHIFT and DONE are ignored.
    doneBefore = doneCount;
    pushExpected(8'd2, 1'b0);
    driveStart(8'd3, 8'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; a = 8'd9; b = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("in DONE", done, 1);
    start = 1'b1; a = 8'd9; b = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("ignored start done count", doneCount - doneBefore, 1);
    checkOutput("ignored start idle", busy, 0);
    checkOutput("ignored start diff", diff, 2);

    // Reset during the 4th SHIFT cycle aborts without a done pulse.
    doneBefore = doneCount;
    for (int i = 0; i < 8; i++) bitQ.push_back(1'b0);
    driveStart(8'd100, 8'd100);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bitQ.delete();
    @(negedge clk);
    checkAllZero("abort");
    repeat (12) @(negedge clk);
    checkOutput("abort no done", doneCount - doneBefore, 0);
    applyStimulus(8'd0, 8'd1, 8'd255, 1'b1);

    // WIDTH=2 instance: 0-0 with a two-cycle SHIFT.
    @(posedge clk); #1;
    start2 = 1'b1; a2 = 2'd0; b2 = 2'd0;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 0;
    busyN = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (busy2) busyN++;
      if (done2) break;
    end
    checkOutput("w2 latency", lat, 3);
    checkOutput("w2 busy cycles", busyN, 2);
    checkOutput("w2 diff", diff2, 0);
    checkOutput("w2 borrow", borrowOut2, 0);
    @(negedge clk);
    checkOutput("w2 done one-cycle", done2, 0);

    repeat (2) @(negedge clk);
    checkOutput("results left", resultQ.size(), 0);
    checkOutput("bits left", bitQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
